// File: rtl/st_32to8_symbol_serializer.sv
// ---------------------------------------------------------------------------
// st_32to8_symbol_serializer
//
// Avalon-ST data format stage that turns a 32-bit, 4-symbol packet stream
// into an 8-bit, 1-symbol stream for the byte-wide MAC transmit path.
// One input beat is buffered and its valid symbols are emitted most
// significant first. SOP/EOP and error bits follow the symbols. On an EOP
// beat, in_empty trims trailing symbols. Ready/valid backpressure is honoured
// on both sides.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   in_ready            sink ready (combinational from state and out_ready)
//   in_valid            sink valid
//   in_data             four symbols, first symbol in the top byte
//   in_error            error bits for the beat
//   in_startofpacket    SOP
//   in_endofpacket      EOP
//   in_empty            unused trailing symbols, only meaningful with EOP
//   out_ready           source ready
//   out_valid           source valid (registered)
//   out_data            current symbol (registered)
//   out_error           error bits of the beat being emitted (registered)
//   out_startofpacket   SOP on the first symbol of an SOP beat (registered)
//   out_endofpacket     EOP on the last valid symbol of an EOP beat (registered)
// ---------------------------------------------------------------------------
module st_32to8_symbol_serializer #(
    parameter int SYMBOL_W = 8,
    parameter int SYMBOLS  = 4,
    parameter int ERROR_W  = 6,
    parameter int EMPTY_W  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic                         in_ready,
    input  logic                         in_valid,
    input  logic [SYMBOL_W*SYMBOLS-1:0]  in_data,
    input  logic [ERROR_W-1:0]           in_error,
    input  logic                         in_startofpacket,
    input  logic                         in_endofpacket,
    input  logic [EMPTY_W-1:0]           in_empty,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [SYMBOL_W-1:0]          out_data,
    output logic [ERROR_W-1:0]           out_error,
    output logic                         out_startofpacket,
    output logic                         out_endofpacket
);

    localparam int DATA_W = SYMBOL_W * SYMBOLS;
    localparam logic [EMPTY_W-1:0] FULL_LAST = EMPTY_W'(SYMBOLS - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t              state;
    // Symbols of the held beat that have not been presented yet; the next
    // one to present always sits in the top symbol slot.
    logic [DATA_W-1:0]   hold_data;
    logic                hold_eop;
    logic [EMPTY_W-1:0]  last_idx;
    logic [EMPTY_W-1:0]  idx;

    logic                busy;
    logic                accept;
    logic                consume;
    logic [EMPTY_W-1:0]  next_idx;
    logic [EMPTY_W-1:0]  load_last;

    assign busy      = (state == EMIT);
    assign next_idx  = idx + 1'b1;
    assign load_last = in_endofpacket ? (FULL_LAST - in_empty) : FULL_LAST;

    // A new beat may enter when idle, or when the last symbol of the held
    // beat leaves in this same cycle (zero-bubble reload).
    assign in_ready  = !busy || (out_ready && (idx == last_idx));
    assign accept    = in_valid && in_ready;
    assign consume   = busy && out_ready;
    assign out_valid = busy;

    // Outputs are loaded with symbol 0 on accept and advanced one symbol per
    // consume. Nothing changes while out_ready is low, which keeps the
    // source side stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            hold_data         <= '0;
            hold_eop          <= 1'b0;
            last_idx          <= '0;
            idx               <= '0;
            out_data          <= '0;
            out_error         <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else if (accept) begin
            state             <= EMIT;
            idx               <= '0;
            last_idx          <= load_last;
            hold_data         <= in_data << SYMBOL_W;
            hold_eop          <= in_endofpacket;
            out_data          <= in_data[DATA_W-1 -: SYMBOL_W];
            out_error         <= in_error;
            out_startofpacket <= in_startofpacket;
            out_endofpacket   <= in_endofpacket && (load_last == '0);
        end else if (consume) begin
            if (idx != last_idx) begin
                idx               <= next_idx;
                hold_data         <= hold_data << SYMBOL_W;
                out_data          <= hold_data[DATA_W-1 -: SYMBOL_W];
                out_startofpacket <= 1'b0;
                out_endofpacket   <= hold_eop && (next_idx == last_idx);
            end else begin
                state             <= IDLE;
                out_startofpacket <= 1'b0;
                out_endofpacket   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_st_32to8_symbol_serializer.sv
// ---------------------------------------------------------------------------
// tb_st_32to8_symbol_serializer
//
// Self-checking bench for st_32to8_symbol_serializer. A reference model
// keeps a queue of the symbols still owed for the accepted beat. Every cycle,
// the DUT outputs and in_ready are compared against the queue head. Directed
// scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_st_32to8_symbol_serializer;

    logic        clk;
    logic        reset_n;
    logic        in_ready;
    logic        in_valid;
    logic [31:0] in_data;
    logic [5:0]  in_error;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_empty;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [5:0]  out_error;
    logic        out_startofpacket;
    logic        out_endofpacket;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [5:0] err;
    } sym_t;

    sym_t exp_q[$];

    st_32to8_symbol_serializer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_error         (out_error),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the model; called mid-cycle on the falling edge.
    task automatic checkOutput();
        logic exp_ready;
        exp_ready = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
        checkValue("in_ready", in_ready, exp_ready);
        checkValue("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            checkValue("out_data", out_data, exp_q[0].data);
            checkValue("out_sop", out_startofpacket, exp_q[0].sop);
            checkValue("out_eop", out_endofpacket, exp_q[0].eop);
            checkValue("out_error", out_error, exp_q[0].err);
        end
    endtask

    // Drive one cycle of inputs, check on the falling edge, update the
    // model with whatever handshakes happen at the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [5:0] e,
                                 input logic sop, input logic eop, input logic [1:0] emp,
                                 input logic ordy);
        int n;
        logic acc;
        logic con;
        sym_t s;
        in_valid         = v;
        in_data          = d;
        in_error         = e;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = emp;
        out_ready        = ordy;
        @(negedge clk);
        checkOutput();
        acc = v && ((exp_q.size() == 0) || (ordy && exp_q.size() == 1));
        con = (exp_q.size() != 0) && ordy;
        if (con) void'(exp_q.pop_front());
        if (acc) begin
            n = eop ? 4 - int'(emp) : 4;
            for (int i = 0; i < n; i++) begin
                s.data = d[31 - 8*i -: 8];
                s.sop  = sop && (i == 0);
                s.eop  = eop && (i == n - 1);
                s.err  = e;
                exp_q.push_back(s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 2'd0, ordy);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_error = '0;
        in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
        out_ready = 1'b1;
        #1;
        checkValue("reset out_valid", out_valid, 0);
        checkValue("reset out_data", out_data, 0);
        checkValue("reset out_error", out_error, 0);
        checkValue("reset out_sop", out_startofpacket, 0);
        checkValue("reset out_eop", out_endofpacket, 0);
        checkValue("reset in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single full beat");
        applyStimulus(1'b1, 32'hA1B2C3D4, 6'h00, 1'b1, 1'b0, 2'd0, 1'b1);
        idleCycles(5, 1'b1);

        $display("[TB] EOP with empty=2");
        applyStimulus(1'b1, 32'h11223344, 6'h00, 1'b0, 1'b1, 2'd2, 1'b1);
        idleCycles(3, 1'b1);

        $display("[TB] back-to-back single-beat packets");
        applyStimulus(1'b1, 32'hAA000000, 6'h00, 1'b1, 1'b1, 2'd3, 1'b1);
        applyStimulus(1'b1, 32'h01020304, 6'h00, 1'b1, 1'b1, 2'd0, 1'b1);
        idleCycles(5, 1'b1);

        $display("[TB] backpressure on symbol 2");
        applyStimulus(1'b1, 32'hDEADBEEF, 6'h00, 1'b1, 1'b0, 2'd0, 1'b1);
        idleCycles(2, 1'b1);
        idleCycles(3, 1'b0);
        idleCycles(3, 1'b1);

        $display("[TB] error propagation");
        applyStimulus(1'b1, 32'h55667788, 6'b100001, 1'b1, 1'b1, 2'd1, 1'b1);
        idleCycles(4, 1'b1);

        $display("[TB] reset mid-beat");
        applyStimulus(1'b1, 32'h12345678, 6'h0A, 1'b1, 1'b0, 2'd0, 1'b1);
        idleCycles(2, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkValue("midreset out_valid", out_valid, 0);
        checkValue("midreset out_data", out_data, 0);
        checkValue("midreset out_sop", out_startofpacket, 0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkValue("postreset in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h9ABCDEF0, 6'h03, 1'b1, 1'b0, 2'd0, 1'b1);
        idleCycles(5, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 6'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        idleCycles(6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
